// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package iter_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Quotient reported for a zero divisor, matching the natural restoring result.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/iter_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, keep or restore.
module div_step
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    assign shifted_s = {rem, dvd_msb};
    assign trial_s   = shifted_s - {1'b0, divisor};

    // A set shifted-out MSB means the partial remainder already exceeds any divisor,
    // so the subtraction must succeed even though bit WIDTH of the trial looks negative.
    assign qbit     = rem[WIDTH-1] | ~trial_s[WIDTH];
    assign rem_next = qbit ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU unit: operands captured on start, one quotient bit per CALC cycle.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(ITER - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ZERO = {DIV_CNT_W{1'b0}};
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return (~x) + W_ONE;
    endfunction

    div_state_e state_r;
    div_state_e state_s;

    logic                 busy_r, done_r;
    logic [DIV_CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0]     a_raw_r, b_raw_r;
    logic                 sd_r;
    logic [WIDTH-1:0]     dvd_r, dvs_r, rem_r;
    logic                 neg_q_r, neg_rem_r, zero_r;
    logic [WIDTH-1:0]     quot_r, remd_r;
    logic                 dz_r;
    logic [WIDTH-1:0]     step_rem_s;
    logic                 step_qbit_s;
    logic [WIDTH-1:0]     fix_quot_s, fix_remd_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .dvd_msb  (dvd_r[WIDTH-1]),
        .divisor  (dvs_r),
        .rem_next (step_rem_s),
        .qbit     (step_qbit_s)
    );

    // State register plus busy/done, registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == LOAD) || (state_s == CALC) || (state_s == FIX);
            done_r  <= (state_s == DONE);
        end
    end

    // Next-state logic; a flush overrides everything, including a simultaneous start.
    always_comb begin
        state_s = state_r;
        if (cancel) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) state_s = LOAD;
                    else       state_s = IDLE;
                end
                LOAD: state_s = CALC;
                CALC: begin
                    if (cnt_r == CNT_ZERO) state_s = FIX;
                    else                   state_s = CALC;
                end
                FIX:     state_s = DONE;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Sign correction; a zero divisor bypasses it and reports the raw dividend.
    always_comb begin
        fix_quot_s = dvd_r;
        fix_remd_s = rem_r;
        if (zero_r) begin
            fix_quot_s = DIV_ZERO_QUOT;
            fix_remd_s = a_raw_r;
        end else begin
            fix_quot_s = neg_q_r   ? twos_neg(dvd_r) : dvd_r;
            fix_remd_s = neg_rem_r ? twos_neg(rem_r) : rem_r;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r     <= CNT_ZERO;
            a_raw_r   <= W_ZERO;
            b_raw_r   <= W_ZERO;
            sd_r      <= 1'b0;
            dvd_r     <= W_ZERO;
            dvs_r     <= W_ZERO;
            rem_r     <= W_ZERO;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            zero_r    <= 1'b0;
            quot_r    <= W_ZERO;
            remd_r    <= W_ZERO;
            dz_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !cancel) begin
                        a_raw_r <= a;
                        b_raw_r <= b;
                        sd_r    <= signed_div;
                    end
                end
                LOAD: begin
                    // The dividend register doubles as the quotient shift register.
                    dvd_r     <= (sd_r && a_raw_r[WIDTH-1]) ? twos_neg(a_raw_r) : a_raw_r;
                    dvs_r     <= (sd_r && b_raw_r[WIDTH-1]) ? twos_neg(b_raw_r) : b_raw_r;
                    rem_r     <= W_ZERO;
                    cnt_r     <= CNT_LAST;
                    neg_q_r   <= sd_r && (a_raw_r[WIDTH-1] ^ b_raw_r[WIDTH-1]);
                    neg_rem_r <= sd_r && a_raw_r[WIDTH-1];
                    zero_r    <= (b_raw_r == W_ZERO);
                end
                CALC: begin
                    rem_r <= step_rem_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], step_qbit_s};
                    if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
                end
                FIX: begin
                    if (!cancel) begin
                        quot_r <= fix_quot_s;
                        remd_r <= fix_remd_s;
                        dz_r   <= zero_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = remd_r;
    assign div_zero  = dz_r;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: latency, signed/unsigned results, div-by-zero, cancel, reset, restart.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, bc;
    logic        snap_busy;
    logic [31:0] snap_q, snap_r;
    logic        snap_dz;

    iter_divider dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    // mode: 0 plain, 1 cancel at abort_k, 2 extra start at abort_k, 3 reset at abort_k
    task automatic do_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input int mode, input int abort_k);
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = av; b = bv;
        lat = 0; bc = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == abort_k + 1) begin
                snap_busy = busy; snap_q = quotient; snap_r = remainder; snap_dz = div_zero;
            end
            if (busy) bc++;
            if (done && lat == 0) lat = k;
            if (k == 1) start = 1'b0;
            if (mode == 1 && k == abort_k)     cancel = 1'b1;
            if (mode == 1 && k == abort_k + 1) cancel = 1'b0;
            if (mode == 2 && k == abort_k) begin
                start = 1'b1; signed_div = ~sd; a = 32'd1; b = 32'd1;
            end
            if (mode == 2 && k == abort_k + 1) start = 1'b0;
            if (mode == 3 && k == abort_k)     resetn = 1'b0;
            if (mode == 3 && k == abort_k + 2) resetn = 1'b1;
            if (lat != 0) break;
        end
        start = 1'b0; cancel = 1'b0; resetn = 1'b1;
    endtask

    task automatic check_result(input string name, input logic [31:0] eq, input logic [31:0] er,
                                input logic edz);
        n_tests++;
        if (lat !== 35) begin n_fail++; $display("FAIL %s latency: got %0d, want 35", name, lat); end
        n_tests++;
        if (quotient !== eq) begin n_fail++; $display("FAIL %s quotient: got %h, want %h", name, quotient, eq); end
        n_tests++;
        if (remainder !== er) begin n_fail++; $display("FAIL %s remainder: got %h, want %h", name, remainder, er); end
        n_tests++;
        if (div_zero !== edz) begin n_fail++; $display("FAIL %s div_zero: got %b, want %b", name, div_zero, edz); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, div_zero} !== 3'b000) begin
            n_fail++; $display("FAIL reset flags: got %b, want 000", {busy, done, div_zero});
        end
        n_tests++;
        if ({quotient, remainder} !== 64'd0) begin
            n_fail++; $display("FAIL reset results: got %h/%h, want 0/0", quotient, remainder);
        end
        resetn = 1'b1;
    endtask

    task automatic test_divu();
        do_div(1'b0, 32'd100, 32'd7, 0, 0);
        check_result("divu_100_7", 32'd14, 32'd2, 1'b0);
        n_tests++;
        if (bc !== 34) begin n_fail++; $display("FAIL divu busy_cycles: got %0d, want 34", bc); end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL divu done_pulse: got %b, want 0", done); end
        do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
        check_result("divu_large", 32'd1, 32'h7FFF_FFFE, 1'b0);
    endtask

    task automatic test_signed();
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check_result("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
        check_result("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    endtask

    task automatic test_overflow();
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check_result("div_ovf", 32'h8000_0000, 32'd0, 1'b0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check_result("divu_ovf_ops", 32'd0, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_div_zero();
        do_div(1'b0, 32'h1234_5678, 32'd0, 0, 0);
        check_result("divu_zero", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd0, 0, 0);
        check_result("div_zero_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    endtask

    task automatic test_cancel();
        do_div(1'b0, 32'd50, 32'd5, 1, 11);
        n_tests++;
        if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL cancel busy: got %b, want 0", snap_busy); end
        n_tests++;
        if (lat !== 0) begin n_fail++; $display("FAIL cancel done: done seen at %0d, want none", lat); end
        n_tests++;
        if ({quotient, remainder, div_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1}) begin
            n_fail++; $display("FAIL cancel held: got %h/%h/%b, want ffffffff/fffffff9/1",
                               quotient, remainder, div_zero);
        end
        do_div(1'b0, 32'd9, 32'd3, 0, 0);
        check_result("after_cancel_9_3", 32'd3, 32'd0, 1'b0);
    endtask

    task automatic test_start_cancel_idle();
        int act;
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; a = 32'd20; b = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        act = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy || done) act++;
            @(negedge clk);
        end
        n_tests++;
        if (act !== 0) begin n_fail++; $display("FAIL start_cancel_idle: active cycles %0d, want 0", act); end
    endtask

    task automatic test_ignored_start();
        do_div(1'b0, 32'd100, 32'd7, 2, 5);
        check_result("ignored_start", 32'd14, 32'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_div(1'b0, 32'd1000, 32'd3, 3, 15);
        n_tests++;
        if ({snap_busy, snap_dz} !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid flags: got %b, want 00", {snap_busy, snap_dz});
        end
        n_tests++;
        if ({snap_q, snap_r} !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid results: got %h/%h, want 0/0", snap_q, snap_r);
        end
        n_tests++;
        if (lat !== 0) begin n_fail++; $display("FAIL reset_mid done: seen at %0d, want none", lat); end
    endtask

    task automatic test_back_to_back();
        do_div(1'b0, 32'd1000, 32'd10, 0, 0);
        check_result("b2b_first", 32'd100, 32'd0, 1'b0);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 0);
        check_result("b2b_second", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_cancel();
        test_start_cancel_idle();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU; the subtract-and-shift counterpart of the datapath adder.
- Sits beside the ALU in EX. The hazard unit stalls the pipeline while busy and writes quotient/remainder to LO/HI on done.
- One quotient bit per cycle from a single 33-bit subtractor; fixed latency.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITER, WIDTH, number of iteration cycles; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request a division; accepted only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- cancel  in  1  flush (exception/branch squash); aborts any operation.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; quotient/remainder valid this cycle.
- quotient  out  WIDTH  result to LO; held until the next accepted start.
- remainder  out  WIDTH  result to HI; held until the next accepted start.
- div_zero  out  1  divisor was zero; valid with done, held like the results.

Behaviour:
- Clock is clk. Reset is resetn: synchronous, active-low, checked at the rising edge.
- Reset values: state = IDLE; busy, done, div_zero, quotient, remainder all 0; iteration counter = 0.
- States:
  - IDLE: start && !cancel -> LOAD.
  - LOAD: latch operand magnitudes and sign flags; clear the remainder register -> CALC.
  - CALC: runs ITER cycles, counter ITER-1 down to 0, then -> FIX.
  - FIX: apply signs, register the outputs -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
- Latency: start high in cycle T (IDLE) gives done high in cycle T+ITER+3 (T+35 for WIDTH=32). busy is high for cycles T+1 through T+ITER+2 and low in the done cycle.
- Back-to-back: start may be asserted in the cycle after done and is accepted.
- Operands: in signed mode, |a| and |b| are taken in LOAD. |-2^31| = 0x80000000, interpreted as unsigned.
- CALC step:
  - shift {rem, dividend} left by 1;
  - trial = {1'b0, rem} - {1'b0, divisor}, 33 bits;
  - trial[32] == 0: rem = trial[31:0] and qbit = 1; otherwise rem is kept and qbit = 0.
- FIX signs: quotient is negated when sign(a) != sign(b); remainder takes the sign of a. Unsigned mode applies no negation.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no flag.
- Divide by zero: full latency is kept; quotient = all ones and remainder = a (raw, as sampled); div_zero = 1. The sign fix is skipped.
- start while not IDLE is ignored; inputs are not re-sampled.
- cancel in any state: next state is IDLE and busy goes to 0 next cycle.
  - No done pulse is produced.
  - Result registers keep their previous values.
  - cancel together with start in IDLE: cancel wins and nothing is accepted.
- A reset in mid-operation behaves as a full reset; done is never emitted for the aborted operation.

Decomposition:
- Package iter_divider_pkg holds:
  - state enum (IDLE, LOAD, CALC, FIX, DONE);
  - DIV_WIDTH = 32;
  - counter width = $clog2(DIV_WIDTH);
  - the DIV_ZERO_QUOT all-ones constant.
- Sub-module div_step: combinational one-iteration cell.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, qbit.
  - Built around the 33-bit subtraction; reused by the CALC state.

Test Plan:
- DIVU a=100, b=7 -> done at T+35; quotient=14, remainder=2, div_zero=0; busy high for exactly 34 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); a=7, b=-2 -> quotient=-3, remainder=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU with the same operands -> quotient=0, remainder=0x80000000.
- DIVU a=0x12345678, b=0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1 on the done cycle.
- Start a division, assert cancel at CALC cycle 10 -> busy=0 next cycle, no done pulse, outputs unchanged. Then start 9/3 -> quotient=3, remainder=0.
- Pulse start again mid-operation with different operands, and separately drive resetn=0 mid-CALC:
  - the extra start is ignored and the original result is correct;
  - the reset case gives all-zero outputs and IDLE, with no done.
